// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read/write/reserve/tap signal bundle for regfile_scoreboard
interface regfile_scoreboard_if #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic RegWrite;
  logic [ADDR_WIDTH-1:0] ReserveRegister;
  logic Reserve;
  logic Busy1;
  logic Busy2;
  logic [WIDTH-1:0] TapData;
  logic Overflow;
  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, ReserveRegister, Reserve,
    input ReadData1, ReadData2, Busy1, Busy2, TapData, Overflow
  );
  modport slave (
    input ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, ReserveRegister, Reserve,
    output ReadData1, ReadData2, Busy1, Busy2, TapData, Overflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with zero reg 0, debug tap and busy scoreboard.
// Define WRITE_BYPASS_EN to forward same-cycle writes to read ports and the tap.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAP_REG = 16
) (
  input logic Clk,
  input logic Reset,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TAP_ADDR = ADDR_WIDTH'(TAP_REG);
  logic [WIDTH-1:0] regs_q [DEPTH] = '{default: '0};
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q = '0;
  logic [DEPTH-1:0] busy_d;
  logic overflow_q = 1'b0;
  logic overflow_d;
  logic wr, res;
  assign wr = bus.RegWrite && bus.WriteRegister != '0;
  assign res = bus.Reserve && bus.ReserveRegister != '0;
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    overflow_d = overflow_q;
    if (Reset) begin
      regs_d = '{default: '0};
      busy_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr) begin
        regs_d[bus.WriteRegister] = bus.WriteData;
        busy_d[bus.WriteRegister] = 1'b0;
        overflow_d = overflow_q || !busy_q[bus.WriteRegister];
      end
      // reserve applied last so a new producer wins over a completing one
      if (res) busy_d[bus.ReserveRegister] = 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
    overflow_q <= overflow_d;
  end
`ifdef WRITE_BYPASS_EN
  logic byp1, byp2, bypt;
  assign byp1 = wr && !Reset && bus.WriteRegister == bus.ReadRegister1;
  assign byp2 = wr && !Reset && bus.WriteRegister == bus.ReadRegister2;
  assign bypt = wr && !Reset && bus.WriteRegister == TAP_ADDR;
  assign bus.ReadData1 = byp1 ? bus.WriteData : regs_q[bus.ReadRegister1];
  assign bus.ReadData2 = byp2 ? bus.WriteData : regs_q[bus.ReadRegister2];
  assign bus.TapData = bypt ? bus.WriteData : regs_q[TAP_ADDR];
  assign bus.Busy1 = byp1 ? (res && bus.ReserveRegister == bus.ReadRegister1) : busy_q[bus.ReadRegister1];
  assign bus.Busy2 = byp2 ? (res && bus.ReserveRegister == bus.ReadRegister2) : busy_q[bus.ReadRegister2];
`else
  assign bus.ReadData1 = regs_q[bus.ReadRegister1];
  assign bus.ReadData2 = regs_q[bus.ReadRegister2];
  assign bus.TapData = regs_q[TAP_ADDR];
  assign bus.Busy1 = busy_q[bus.ReadRegister1];
  assign bus.Busy2 = busy_q[bus.ReadRegister2];
`endif
  assign bus.Overflow = overflow_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
  logic Clk = 1'b0;
  logic Reset;
  int pass_cnt = 0;
  int total = 0;
  regfile_scoreboard_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();
  regfile_scoreboard #(.WIDTH(32), .ADDR_WIDTH(5), .TAP_REG(16)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus.slave)
  );
  always #5 Clk = ~Clk;
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic idle;
    bus.RegWrite = 1'b0;
    bus.Reserve = 1'b0;
    Reset = 1'b0;
  endtask
  task automatic test_reset;
    Reset = 1'b1;
    bus.RegWrite = 1'b0;
    bus.Reserve = 1'b0;
    bus.WriteRegister = '0;
    bus.WriteData = '0;
    bus.ReserveRegister = '0;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
    step();
    idle();
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      bus.ReadRegister2 = 5'(31 - i);
      #1;
      total++;
      if (bus.ReadData1 !== 32'd0 || bus.ReadData2 !== 32'd0 || bus.Busy1 !== 1'b0 || bus.Busy2 !== 1'b0)
        $display("FAIL reset_read[%0d] rd1=%h rd2=%h b1=%b b2=%b want 0", i, bus.ReadData1, bus.ReadData2, bus.Busy1, bus.Busy2);
      else pass_cnt++;
    end
    total++;
    if (bus.TapData !== 32'd0 || bus.Overflow !== 1'b0)
      $display("FAIL reset_tap_ovf tap=%h ovf=%b want 0/0", bus.TapData, bus.Overflow);
    else pass_cnt++;
  endtask
  task automatic test_reserve_write;
    bus.ReadRegister1 = 5'd16;
    bus.Reserve = 1'b1;
    bus.ReserveRegister = 5'd16;
    step();
    idle();
    #1;
    total++;
    if (bus.Busy1 !== 1'b1) $display("FAIL rw_busy_set got %b want 1", bus.Busy1);
    else pass_cnt++;
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd16;
    bus.WriteData = 32'd2467;
    step();
    idle();
    #1;
    total++;
    if (bus.Busy1 !== 1'b0) $display("FAIL rw_busy_clr got %b want 0", bus.Busy1);
    else pass_cnt++;
    total++;
    if (bus.ReadData1 !== 32'd2467) $display("FAIL rw_data got %0d want 2467", bus.ReadData1);
    else pass_cnt++;
    total++;
    if (bus.TapData !== 32'd2467) $display("FAIL rw_tap got %0d want 2467", bus.TapData);
    else pass_cnt++;
    total++;
    if (bus.Overflow !== 1'b0) $display("FAIL rw_ovf got %b want 0", bus.Overflow);
    else pass_cnt++;
  endtask
  task automatic test_reg0;
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd0;
    bus.WriteData = 32'hFFFF_FFFF;
    bus.Reserve = 1'b1;
    bus.ReserveRegister = 5'd0;
    bus.ReadRegister1 = 5'd0;
    step();
    idle();
    #1;
    total++;
    if (bus.ReadData1 !== 32'd0 || bus.Busy1 !== 1'b0 || bus.Overflow !== 1'b0)
      $display("FAIL reg0 rd=%h busy=%b ovf=%b want 0/0/0", bus.ReadData1, bus.Busy1, bus.Overflow);
    else pass_cnt++;
  endtask
  task automatic test_same_cycle;
    bus.Reserve = 1'b1;
    bus.ReserveRegister = 5'd5;
    step();
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd5;
    bus.WriteData = 32'hA5A5_A5A5;
    step();
    idle();
    bus.ReadRegister2 = 5'd5;
    #1;
    total++;
    if (bus.ReadData2 !== 32'hA5A5_A5A5) $display("FAIL same_data got %h want a5a5a5a5", bus.ReadData2);
    else pass_cnt++;
    total++;
    if (bus.Busy2 !== 1'b1) $display("FAIL same_busy got %b want 1", bus.Busy2);
    else pass_cnt++;
    total++;
    if (bus.Overflow !== 1'b0) $display("FAIL same_ovf got %b want 0", bus.Overflow);
    else pass_cnt++;
  endtask
  task automatic test_overflow;
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd7;
    bus.WriteData = 32'd42;
    step();
    idle();
    #1;
    total++;
    if (bus.Overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.Overflow);
    else pass_cnt++;
    step();
    total++;
    if (bus.Overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus.Overflow);
    else pass_cnt++;
    Reset = 1'b1;
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd9;
    bus.WriteData = 32'd3;
    step();
    idle();
    bus.ReadRegister1 = 5'd9;
    bus.ReadRegister2 = 5'd5;
    #1;
    total++;
    if (bus.ReadData1 !== 32'd0) $display("FAIL rst_write got %0d want 0", bus.ReadData1);
    else pass_cnt++;
    total++;
    if (bus.Overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", bus.Overflow);
    else pass_cnt++;
    total++;
    if (bus.ReadData2 !== 32'd0 || bus.Busy2 !== 1'b0 || bus.TapData !== 32'd0)
      $display("FAIL rst_state rd2=%h busy2=%b tap=%h want 0", bus.ReadData2, bus.Busy2, bus.TapData);
    else pass_cnt++;
  endtask
  task automatic test_bypass;
    logic [31:0] exp_rd, exp_tap;
`ifdef WRITE_BYPASS_EN
    exp_rd = 32'd99;
    exp_tap = 32'd77;
`else
    exp_rd = 32'd0;
    exp_tap = 32'd0;
`endif
    bus.ReadRegister2 = 5'd3;
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd3;
    bus.WriteData = 32'd99;
    #1;
    total++;
    if (bus.ReadData2 !== exp_rd) $display("FAIL byp_pre got %0d want %0d", bus.ReadData2, exp_rd);
    else pass_cnt++;
    step();
    idle();
    #1;
    total++;
    if (bus.ReadData2 !== 32'd99) $display("FAIL byp_post got %0d want 99", bus.ReadData2);
    else pass_cnt++;
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'd16;
    bus.WriteData = 32'd77;
    #1;
    total++;
    if (bus.TapData !== exp_tap) $display("FAIL byp_tap got %0d want %0d", bus.TapData, exp_tap);
    else pass_cnt++;
    step();
    idle();
    #1;
    total++;
    if (bus.TapData !== 32'd77) $display("FAIL tap_post got %0d want 77", bus.TapData);
    else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_reserve_write();
    test_reg0();
    test_same_cycle();
    test_overflow();
    test_bypass();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
